// File: rtl/fe_invert_ctrl.sv
// Field inversion sequencer for GF(2^255-19): walks the ref10 addition chain and drives
// the shared fe_sq / fe_mul units over start/done handshakes. Operand limbs pass through untouched.
module fe_invert_ctrl #(
    parameter int FE_W  = 320,
    parameter int REP_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [FE_W-1:0] z,
    output logic [FE_W-1:0] h,
    output logic            done,
    output logic            busy,
    output logic            sq_start,
    output logic [FE_W-1:0] sq_f,
    input  logic [FE_W-1:0] sq_h,
    input  logic            sq_done,
    output logic            mul_start,
    output logic [FE_W-1:0] mul_f,
    output logic [FE_W-1:0] mul_g,
    input  logic [FE_W-1:0] mul_h,
    input  logic            mul_done
);

    localparam int ROM_W = 9 + REP_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    localparam logic OP_SQ  = 1'b0;
    localparam logic OP_MUL = 1'b1;

    localparam logic [2:0] SRC_Z  = 3'd0;
    localparam logic [2:0] SRC_T0 = 3'd1;
    localparam logic [2:0] SRC_T1 = 3'd2;
    localparam logic [2:0] SRC_T2 = 3'd3;
    localparam logic [2:0] SRC_T3 = 3'd4;

    localparam logic [1:0] D_T0 = 2'd0;
    localparam logic [1:0] D_T1 = 2'd1;
    localparam logic [1:0] D_T2 = 2'd2;
    localparam logic [1:0] D_T3 = 2'd3;

    localparam logic [4:0] LAST_STEP = 5'd21;

    // Entry layout {op, a, b, dst, count}; count is the number of chained squarings.
    function automatic logic [ROM_W-1:0] rom_entry(input logic [4:0] idx);
        logic [ROM_W-1:0] e;
        case (idx)
            5'd0:    e = {OP_SQ,  SRC_Z,  SRC_Z,  D_T0, REP_W'(1)};
            5'd1:    e = {OP_SQ,  SRC_T0, SRC_Z,  D_T1, REP_W'(2)};
            5'd2:    e = {OP_MUL, SRC_Z,  SRC_T1, D_T1, REP_W'(1)};
            5'd3:    e = {OP_MUL, SRC_T0, SRC_T1, D_T0, REP_W'(1)};
            5'd4:    e = {OP_SQ,  SRC_T0, SRC_Z,  D_T2, REP_W'(1)};
            5'd5:    e = {OP_MUL, SRC_T1, SRC_T2, D_T1, REP_W'(1)};
            5'd6:    e = {OP_SQ,  SRC_T1, SRC_Z,  D_T2, REP_W'(5)};
            5'd7:    e = {OP_MUL, SRC_T2, SRC_T1, D_T1, REP_W'(1)};
            5'd8:    e = {OP_SQ,  SRC_T1, SRC_Z,  D_T2, REP_W'(10)};
            5'd9:    e = {OP_MUL, SRC_T2, SRC_T1, D_T2, REP_W'(1)};
            5'd10:   e = {OP_SQ,  SRC_T2, SRC_Z,  D_T3, REP_W'(20)};
            5'd11:   e = {OP_MUL, SRC_T3, SRC_T2, D_T2, REP_W'(1)};
            5'd12:   e = {OP_SQ,  SRC_T2, SRC_Z,  D_T2, REP_W'(10)};
            5'd13:   e = {OP_MUL, SRC_T2, SRC_T1, D_T1, REP_W'(1)};
            5'd14:   e = {OP_SQ,  SRC_T1, SRC_Z,  D_T2, REP_W'(50)};
            5'd15:   e = {OP_MUL, SRC_T2, SRC_T1, D_T2, REP_W'(1)};
            5'd16:   e = {OP_SQ,  SRC_T2, SRC_Z,  D_T3, REP_W'(100)};
            5'd17:   e = {OP_MUL, SRC_T3, SRC_T2, D_T2, REP_W'(1)};
            5'd18:   e = {OP_SQ,  SRC_T2, SRC_Z,  D_T2, REP_W'(50)};
            5'd19:   e = {OP_MUL, SRC_T2, SRC_T1, D_T1, REP_W'(1)};
            5'd20:   e = {OP_SQ,  SRC_T1, SRC_Z,  D_T1, REP_W'(5)};
            5'd21:   e = {OP_MUL, SRC_T1, SRC_T0, D_T1, REP_W'(1)};
            default: e = '0;
        endcase
        return e;
    endfunction

    logic [2:0]      state;
    logic [4:0]      step;
    logic [REP_W-1:0] rep;
    logic            first;
    logic [FE_W-1:0] z_r, t0, t1, t2, t3;

    logic            op;
    logic [2:0]      a_sel, b_sel;
    logic [1:0]      dst_sel;
    logic [REP_W-1:0] cnt;
    logic [FE_W-1:0] a_val, b_val, d_val, res;
    logic            srv_done;

    assign {op, a_sel, b_sel, dst_sel, cnt} = rom_entry(step);
    assign res      = (op == OP_MUL) ? mul_h : sq_h;
    assign srv_done = (op == OP_MUL) ? mul_done : sq_done;

    always_comb begin
        a_val = z_r;
        case (a_sel)
            SRC_T0:  a_val = t0;
            SRC_T1:  a_val = t1;
            SRC_T2:  a_val = t2;
            SRC_T3:  a_val = t3;
            default: a_val = z_r;
        endcase
        b_val = z_r;
        case (b_sel)
            SRC_T0:  b_val = t0;
            SRC_T1:  b_val = t1;
            SRC_T2:  b_val = t2;
            SRC_T3:  b_val = t3;
            default: b_val = z_r;
        endcase
        d_val = t0;
        case (dst_sel)
            D_T1:    d_val = t1;
            D_T2:    d_val = t2;
            D_T3:    d_val = t3;
            default: d_val = t0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            step      <= '0;
            rep       <= '0;
            first     <= 1'b0;
            z_r       <= '0;
            t0        <= '0;
            t1        <= '0;
            t2        <= '0;
            t3        <= '0;
            h         <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            sq_start  <= 1'b0;
            sq_f      <= '0;
            mul_start <= 1'b0;
            mul_f     <= '0;
            mul_g     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        z_r   <= z;
                        busy  <= 1'b1;
                        step  <= '0;
                        first <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (first)
                        rep <= cnt;
                    // Repeated squarings after the first feed back the previous result.
                    if (op == OP_SQ) begin
                        sq_f     <= first ? a_val : d_val;
                        sq_start <= 1'b1;
                    end else begin
                        mul_f     <= a_val;
                        mul_g     <= b_val;
                        mul_start <= 1'b1;
                    end
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (srv_done) begin
                        case (dst_sel)
                            D_T0:    t0 <= res;
                            D_T1:    t1 <= res;
                            D_T2:    t2 <= res;
                            default: t3 <= res;
                        endcase
                        sq_start  <= 1'b0;
                        mul_start <= 1'b0;
                        state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    sq_start  <= 1'b0;
                    mul_start <= 1'b0;
                    if (!srv_done)
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    if (op == OP_SQ && rep > REP_W'(1)) begin
                        rep   <= rep - REP_W'(1);
                        first <= 1'b0;
                        state <= S_ISSUE;
                    end else if (step == LAST_STEP) begin
                        state <= S_FINISH;
                    end else begin
                        step  <= step + 5'd1;
                        first <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    h    <= t1;
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (!start)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fe_invert_ctrl.sv
// Bench for fe_invert_ctrl: behavioural fe_sq/fe_mul servants, reference inversion by
// square-and-multiply over 2^255-19, and handshake/edge monitors.
module tb_fe_invert_ctrl;

    localparam int FE_W = 320;
    localparam logic [511:0] P = (512'd1 << 255) - 512'd19;

    logic            clk = 1'b0;
    logic            reset, start;
    logic [FE_W-1:0] z, h, sq_f, sq_h, mul_f, mul_g, mul_h;
    logic            done, busy, sq_start, sq_done, mul_start, mul_done;

    int vectors = 0;
    int miscompares = 0;
    int srv_lat = 0;

    always #5 clk = ~clk;

    fe_invert_ctrl #(.FE_W(FE_W), .REP_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .z(z), .h(h), .done(done), .busy(busy),
        .sq_start(sq_start), .sq_f(sq_f), .sq_h(sq_h), .sq_done(sq_done),
        .mul_start(mul_start), .mul_f(mul_f), .mul_g(mul_g), .mul_h(mul_h), .mul_done(mul_done)
    );

    function automatic int off(input int i);
        return (i * 51 + 1) / 2;
    endfunction

    function automatic logic [511:0] fe2int(input logic [FE_W-1:0] f);
        logic signed [511:0] acc, term, pm;
        acc = '0;
        pm  = $signed(P);
        for (int i = 0; i < 10; i++) begin
            term = $signed({{480{f[32*i+31]}}, f[32*i +: 32]});
            acc  = acc + (term <<< off(i));
        end
        acc = acc % pm;
        if (acc < 0)
            acc = acc + pm;
        return acc;
    endfunction

    function automatic logic [FE_W-1:0] int2fe(input logic [511:0] v);
        logic [FE_W-1:0] f;
        logic [511:0] t;
        int w;
        f = '0;
        for (int i = 0; i < 10; i++) begin
            w = (i % 2 == 0) ? 26 : 25;
            t = (v >> off(i)) & ((512'd1 << w) - 512'd1);
            f[32*i +: 32] = t[31:0];
        end
        return f;
    endfunction

    function automatic logic [511:0] mulmod(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] pr;
        pr = (a % P) * (b % P);
        return pr % P;
    endfunction

    function automatic logic [511:0] inv_ref(input logic [511:0] a);
        logic [511:0] e, r;
        e = P - 512'd2;
        r = 512'd1;
        for (int i = 254; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i])
                r = mulmod(r, a);
        end
        return r;
    endfunction

    function automatic logic [FE_W-1:0] fe_mul_model(input logic [FE_W-1:0] a, input logic [FE_W-1:0] b);
        return int2fe(mulmod(fe2int(a), fe2int(b)));
    endfunction

    // Servant models: done after srv_lat cycles, held until start drops, then cleared.
    logic sq_busy = 1'b0, mul_busy = 1'b0;
    int sq_cnt = 0, mul_cnt = 0;
    logic [FE_W-1:0] sq_res, mul_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sq_done <= 1'b0;
            sq_busy <= 1'b0;
            sq_cnt  <= 0;
        end else if (!sq_busy && sq_start && !sq_done) begin
            if (srv_lat == 0) begin
                sq_done <= 1'b1;
                sq_h    <= fe_mul_model(sq_f, sq_f);
            end else begin
                sq_busy <= 1'b1;
                sq_cnt  <= srv_lat;
                sq_res  <= fe_mul_model(sq_f, sq_f);
            end
        end else if (sq_busy) begin
            if (sq_cnt <= 1) begin
                sq_done <= 1'b1;
                sq_h    <= sq_res;
                sq_busy <= 1'b0;
            end else begin
                sq_cnt <= sq_cnt - 1;
            end
        end else if (sq_done && !sq_start) begin
            sq_done <= 1'b0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_done <= 1'b0;
            mul_busy <= 1'b0;
            mul_cnt  <= 0;
        end else if (!mul_busy && mul_start && !mul_done) begin
            if (srv_lat == 0) begin
                mul_done <= 1'b1;
                mul_h    <= fe_mul_model(mul_f, mul_g);
            end else begin
                mul_busy <= 1'b1;
                mul_cnt  <= srv_lat;
                mul_res  <= fe_mul_model(mul_f, mul_g);
            end
        end else if (mul_busy) begin
            if (mul_cnt <= 1) begin
                mul_done <= 1'b1;
                mul_h    <= mul_res;
                mul_busy <= 1'b0;
            end else begin
                mul_cnt <= mul_cnt - 1;
            end
        end else if (mul_done && !mul_start) begin
            mul_done <= 1'b0;
        end
    end

    int sq_edges = 0, mul_edges = 0, overlap = 0;
    logic sq_prev = 1'b0, mul_prev = 1'b0;
    logic [FE_W-1:0] mf_ring [16];
    logic [FE_W-1:0] mg_ring [16];

    always @(negedge clk) begin
        if (sq_start && !sq_prev) begin
            sq_edges <= sq_edges + 1;
            if (sq_done)
                overlap <= overlap + 1;
        end
        if (mul_start && !mul_prev) begin
            mul_edges <= mul_edges + 1;
            mf_ring[mul_edges[3:0]] <= mul_f;
            mg_ring[mul_edges[3:0]] <= mul_g;
            if (mul_done)
                overlap <= overlap + 1;
        end
        sq_prev  <= sq_start;
        mul_prev <= mul_start;
    end

    function automatic logic [511:0] rand_elem();
        logic [255:0] r;
        logic [511:0] v;
        r = '0;
        for (int i = 0; i < 8; i++)
            r = {r[223:0], 32'($urandom())};
        r[255] = 1'b0;
        v = {256'd0, r} % P;
        if (v == 512'd0)
            v = 512'd3;
        return v;
    endfunction

    // Runs one inversion with start held until done; z is scrambled after acceptance.
    task automatic run_inv(input logic [FE_W-1:0] zf, input int lat, output logic [FE_W-1:0] hres,
                           output int sqc, output int mulc, output int ovl, output logic busy_acc,
                           output logic tmo);
        int s0, m0, o0;
        srv_lat = lat;
        s0 = sq_edges;
        m0 = mul_edges;
        o0 = overlap;
        @(posedge clk); #1;
        z = zf;
        start = 1'b1;
        @(posedge clk); #1;
        busy_acc = busy;
        z = int2fe(rand_elem());
        tmo = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        hres = h;
        sqc  = sq_edges - s0;
        mulc = mul_edges - m0;
        ovl  = overlap - o0;
        if (tmo) begin
            reset = 1'b1;
            start = 1'b0;
            #2 reset = 1'b0;
        end
    endtask

    task automatic drop_start();
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        z = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({h, sq_f, mul_f, mul_g} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got h=%h sq_f=%h mul_f=%h mul_g=%h, want all 0", h, sq_f, mul_f, mul_g);
        end
        vectors++;
        if ({done, busy, sq_start, mul_start} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got done/busy/sq_start/mul_start=%b, want 0000", {done, busy, sq_start, mul_start});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_one();
        logic [FE_W-1:0] hr;
        int sqc, mulc, ovl;
        logic ba, tmo;
        run_inv(int2fe(512'd1), 0, hr, sqc, mulc, ovl, ba, tmo);
        vectors++;
        if (tmo !== 1'b0) begin miscompares++; $display("FAIL one_timeout: done never rose"); end
        vectors++;
        if (hr !== int2fe(512'd1)) begin miscompares++; $display("FAIL one_h: got %h want %h", hr, int2fe(512'd1)); end
        vectors++;
        if (ba !== 1'b1) begin miscompares++; $display("FAIL one_busy_accept: got %b want 1", ba); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL one_busy_done: got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || h !== int2fe(512'd1)) begin
            miscompares++;
            $display("FAIL one_hold: got done=%b h=%h want done=1 h=1", done, h);
        end
        drop_start();
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL one_done_drop: got %b want 0", done); end
    endtask

    task automatic test_zero();
        logic [FE_W-1:0] hr;
        int sqc, mulc, ovl;
        logic ba, tmo;
        run_inv('0, 0, hr, sqc, mulc, ovl, ba, tmo);
        drop_start();
        vectors++;
        if (hr !== '0 || tmo) begin miscompares++; $display("FAIL zero_h: got %h tmo=%b want 0", hr, tmo); end
        vectors++;
        if (sqc !== 254) begin miscompares++; $display("FAIL zero_sq_count: got %0d want 254", sqc); end
        vectors++;
        if (mulc !== 11) begin miscompares++; $display("FAIL zero_mul_count: got %0d want 11", mulc); end
    endtask

    task automatic test_two();
        logic [FE_W-1:0] hr;
        int sqc, mulc, ovl, m0;
        logic ba, tmo;
        m0 = mul_edges;
        run_inv(int2fe(512'd2), 0, hr, sqc, mulc, ovl, ba, tmo);
        drop_start();
        vectors++;
        if (hr !== int2fe(inv_ref(512'd2))) begin
            miscompares++;
            $display("FAIL two_h: got %h want %h", hr, int2fe(inv_ref(512'd2)));
        end
        vectors++;
        if (mulmod(512'd2, fe2int(hr)) !== 512'd1) begin
            miscompares++;
            $display("FAIL two_product: got %h want 1", mulmod(512'd2, fe2int(hr)));
        end
        vectors++;
        if (mf_ring[m0 % 16] !== int2fe(512'd2) || mg_ring[m0 % 16] !== int2fe(512'd256)) begin
            miscompares++;
            $display("FAIL two_first_mul: got f=%h g=%h want f=2 g=256", mf_ring[m0 % 16], mg_ring[m0 % 16]);
        end
    endtask

    task automatic test_slow_servant();
        logic [FE_W-1:0] hr;
        logic [511:0] zi;
        int sqc, mulc, ovl;
        logic ba, tmo;
        zi = rand_elem();
        run_inv(int2fe(zi), 3, hr, sqc, mulc, ovl, ba, tmo);
        drop_start();
        vectors++;
        if (hr !== int2fe(inv_ref(zi)) || tmo) begin
            miscompares++;
            $display("FAIL slow_h: got %h want %h", hr, int2fe(inv_ref(zi)));
        end
        vectors++;
        if (ovl !== 0) begin miscompares++; $display("FAIL slow_start_during_done: got %0d want 0", ovl); end
        vectors++;
        if (sqc !== 254 || mulc !== 11) begin
            miscompares++;
            $display("FAIL slow_counts: got sq=%0d mul=%0d want 254/11", sqc, mulc);
        end
    endtask

    task automatic test_reset_mid();
        logic [FE_W-1:0] hr;
        int sqc, mulc, ovl, s0;
        logic ba, tmo, hit;
        srv_lat = 0;
        s0 = sq_edges;
        @(posedge clk); #1;
        z = int2fe(rand_elem());
        start = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (sq_edges - s0 >= 100) begin
                hit = 1'b1;
                break;
            end
        end
        vectors++;
        if (hit !== 1'b1) begin miscompares++; $display("FAIL mid_reach_100: got %0d sq edges want 100", sq_edges - s0); end
        reset = 1'b1;
        #1;
        vectors++;
        if ({h, sq_f, mul_f, mul_g} !== '0 || {done, busy, sq_start, mul_start} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got ctrl=%b h=%h sq_f=%h", {done, busy, sq_start, mul_start}, h, sq_f);
        end
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_inv(int2fe(512'd1), 0, hr, sqc, mulc, ovl, ba, tmo);
        drop_start();
        vectors++;
        if (hr !== int2fe(512'd1) || tmo) begin miscompares++; $display("FAIL mid_restart_h: got %h want 1", hr); end
    endtask

    task automatic test_random();
        logic [FE_W-1:0] hr;
        logic [511:0] zi;
        int sqc, mulc, ovl;
        logic ba, tmo;
        for (int n = 0; n < 50; n++) begin
            zi = rand_elem();
            run_inv(int2fe(zi), 0, hr, sqc, mulc, ovl, ba, tmo);
            drop_start();
            vectors++;
            if (hr !== int2fe(inv_ref(zi)) || tmo) begin
                miscompares++;
                $display("FAIL rand_h[%0d]: got %h want %h", n, hr, int2fe(inv_ref(zi)));
            end
            vectors++;
            if (mulmod(fe2int(hr), zi) !== 512'd1) begin
                miscompares++;
                $display("FAIL rand_product[%0d]: got %h want 1", n, mulmod(fe2int(hr), zi));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        z = '0;
        test_reset();
        test_one();
        test_zero();
        test_two();
        test_slow_servant();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
